// File: rtl/sample_mixer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sample_mixer_pkg                                             |
// | Description : Shared types and constants for the sample mixer.             |
// |               state_t  - mixer FSM state encoding                          |
// |               NUM_VOICES_DEF, SILENCE, acc_w() accumulator width helper    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sample_mixer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUM  = 2'd1,
      NORM = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam int         NUM_VOICES_DEF = 4;
   localparam logic [7:0] SILENCE        = 8'h00;

   // Width that holds NUM_VOICES 8-bit samples summed without overflow.
   function automatic int acc_w(input int n);
      return 8 + $clog2(n);
   endfunction

endpackage : sample_mixer_pkg
`default_nettype wire

// File: rtl/mix_norm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mix_norm                                                     |
// | Description : Sequential restoring divider. One quotient bit per cycle,    |
// |               MSB first; done pulses in the ACC_W-th cycle after start     |
// |               with the final quotient on quotient_o in that same cycle.    |
// | Ports       : clk, n_rst      - clock, synchronous active-low reset        |
// |               start_i         - one-cycle pulse, latches operands          |
// |               dividend_i      - ACC_W-bit dividend                         |
// |               divisor_i       - 4-bit non-zero divisor                     |
// |               quotient_o      - low 8 bits of quotient (valid with done_o) |
// |               done_o          - one-cycle completion pulse                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mix_norm #(
   parameter int ACC_W = 10
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start_i,
   input  logic [ACC_W-1:0] dividend_i,
   input  logic [3:0]       divisor_i,
   output logic [7:0]       quotient_o,
   output logic             done_o
);

   localparam int CNT_W = $clog2(ACC_W + 1);

   // quo_q starts as the dividend; each step shifts a dividend bit out of
   // the top and a quotient bit in at the bottom.
   logic [ACC_W-1:0] quo_q, quo_d;
   logic [3:0]       rem_q, rem_d;
   logic [3:0]       div_q;
   logic [CNT_W-1:0] bits_q;
   logic [4:0]       rem_sh;
   logic             qbit;

   always_comb begin
      rem_sh = {rem_q, quo_q[ACC_W-1]};
      qbit   = 1'b0;
      rem_d  = rem_sh[3:0];
      if (rem_sh >= {1'b0, div_q}) begin
         qbit  = 1'b1;
         rem_d = 4'(rem_sh - {1'b0, div_q});
      end
      quo_d = {quo_q[ACC_W-2:0], qbit};
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         quo_q  <= '0;
         rem_q  <= '0;
         div_q  <= '0;
         bits_q <= '0;
      end else if (start_i) begin
         quo_q  <= dividend_i;
         rem_q  <= '0;
         div_q  <= divisor_i;
         bits_q <= CNT_W'(ACC_W);
      end else if (bits_q != '0) begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         bits_q <= bits_q - CNT_W'(1);
      end
   end

   // The mean of 8-bit samples never exceeds 255, so the top bits are zero.
   assign quotient_o = quo_d[7:0];
   assign done_o     = (bits_q == CNT_W'(1));

endmodule : mix_norm
`default_nettype wire

// File: rtl/sample_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sample_mixer                                                 |
// | Description : Averages the latest 8-bit samples of the active voices into  |
// |               one mixed sample per frame. Serial sum, then restoring       |
// |               division by the active-voice count.                          |
// | Macro       : SAMPLE_MIXER_FRESH_EN - only voices that delivered a done    |
// |               pulse since the previous snapshot are mixed.                 |
// | Ports       : clk, n_rst      - clock, synchronous active-low reset        |
// |               sample_now      - frame strobe                               |
// |               voice_sample    - packed samples, voice i at [8i+7:8i]       |
// |               voice_done      - per-voice sample qualifier                 |
// |               voice_active    - per-voice key-held flag                    |
// |               mix_out         - mixed sample, held between frames          |
// |               mix_valid       - one-cycle pulse when mix_out updates       |
// |               busy            - frame in progress                          |
// |               overrun         - sticky: strobe arrived while busy          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sample_mixer
   import sample_mixer_pkg::*;
#(
   parameter int NUM_VOICES = NUM_VOICES_DEF,
   parameter int ACC_W      = acc_w(NUM_VOICES)
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    sample_now,
   input  logic [8*NUM_VOICES-1:0] voice_sample,
   input  logic [NUM_VOICES-1:0]   voice_done,
   input  logic [NUM_VOICES-1:0]   voice_active,
   output logic [7:0]              mix_out,
   output logic                    mix_valid,
   output logic                    busy,
   output logic                    overrun
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   state_t                  state_q;
   logic [8*NUM_VOICES-1:0] hold_q;
   logic [8*NUM_VOICES-1:0] snap_q;
   logic [NUM_VOICES-1:0]   snap_act_q;
   logic [NUM_VOICES-1:0]   act_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q;
   logic [7:0]              cur_sample;
   logic                    last_voice;
   logic                    norm_start;
   logic [7:0]              norm_quot;
   logic                    norm_done;
   logic [7:0]              mix_out_q;
   logic                    mix_valid_q;
   logic                    overrun_q;

   // Capture runs in every state; a done pulse coinciding with the
   // snapshot lands here after snap_q has taken the previous value.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         hold_q <= '0;
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_done[i]) begin
               hold_q[8*i +: 8] <= voice_sample[8*i +: 8];
            end
         end
      end
   end

`ifdef SAMPLE_MIXER_FRESH_EN
   logic [NUM_VOICES-1:0] fresh_q;
   logic                  snap_take;

   assign snap_take = (state_q == IDLE) && sample_now;

   // Set wins over the snapshot clear so a coincident sample counts next frame.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         fresh_q <= '0;
      end else begin
         fresh_q <= voice_done | (fresh_q & ~{NUM_VOICES{snap_take}});
      end
   end

   assign act_d = voice_active & fresh_q;
`else
   assign act_d = voice_active;
`endif

   // One accumulation step for the voice selected by idx_q.
   always_comb begin
      cur_sample = snap_q[int'(idx_q)*8 +: 8];
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      if (snap_act_q[idx_q]) begin
         acc_d = acc_q + ACC_W'(cur_sample);
         cnt_d = cnt_q + 4'd1;
      end
      last_voice = (idx_q == IDX_W'(NUM_VOICES - 1));
      // Launch the divider on the final sum step so NORM lasts exactly ACC_W cycles.
      norm_start = (state_q == SUM) && last_voice && (cnt_d != 4'd0);
   end

   mix_norm #(
      .ACC_W (ACC_W)
   ) u_norm (
      .clk        (clk),
      .n_rst      (n_rst),
      .start_i    (norm_start),
      .dividend_i (acc_d),
      .divisor_i  (cnt_d),
      .quotient_o (norm_quot),
      .done_o     (norm_done)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         snap_q      <= '0;
         snap_act_q  <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         mix_out_q   <= '0;
         mix_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         mix_valid_q <= 1'b0;
         if (sample_now && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (sample_now) begin
                  snap_q     <= hold_q;
                  snap_act_q <= act_d;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  idx_q      <= '0;
                  state_q    <= SUM;
               end
            end
            SUM: begin
               acc_q <= acc_d;
               cnt_q <= cnt_d;
               if (last_voice) begin
                  idx_q   <= '0;
                  state_q <= NORM;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            NORM: begin
               // Outputs are loaded on entry to OUT so they are visible during it.
               if (cnt_q == 4'd0) begin
                  mix_out_q   <= SILENCE;
                  mix_valid_q <= 1'b1;
                  state_q     <= OUT;
               end else if (norm_done) begin
                  mix_out_q   <= norm_quot;
                  mix_valid_q <= 1'b1;
                  state_q     <= OUT;
               end
            end
            OUT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mix_out   = mix_out_q;
   assign mix_valid = mix_valid_q;
   assign busy      = (state_q != IDLE);
   assign overrun   = overrun_q;

endmodule : sample_mixer
`default_nettype wire

// File: tb/tb_sample_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sample_mixer                                              |
// | Description : Scoreboard bench for sample_mixer. The driver keeps a        |
// |               frame-level model (last sample per voice, freshness) and     |
// |               queues the expected mean and its cycle; a negedge monitor    |
// |               pops on mix_valid and checks busy/overrun/mix_out each cycle.|
// | Macro       : SAMPLE_MIXER_FRESH_EN - model follows the freshness rule.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sample_mixer;

   localparam int NV = 4;
   localparam int AW = 10;
`ifdef SAMPLE_MIXER_FRESH_EN
   localparam bit USE_FRESH = 1'b1;
`else
   localparam bit USE_FRESH = 1'b0;
`endif

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          sample_now;
   logic [8*NV-1:0] voice_sample;
   logic [NV-1:0] voice_done;
   logic [NV-1:0] voice_active;
   logic [7:0]    mix_out;
   logic          mix_valid;
   logic          busy;
   logic          overrun;

   sample_mixer #(
      .NUM_VOICES (NV),
      .ACC_W      (AW)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .sample_now   (sample_now),
      .voice_sample (voice_sample),
      .voice_done   (voice_done),
      .voice_active (voice_active),
      .mix_out      (mix_out),
      .mix_valid    (mix_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state
   int   m_hold  [NV];
   bit   m_fresh [NV];
   exp_t q [$];
   int   exp_mix;
   int   fs, fo;       // busy window of the frame in flight
   int   ovr_cyc;      // first cycle overrun is expected high
   bit   mon_en = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [NV-1:0] cur_act;
   exp_t e;

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NV; i++) begin
         m_hold[i]  = 0;
         m_fresh[i] = 1'b0;
      end
      q.delete();
      exp_mix = 0;
      fs      = 0;
      fo      = -1;
      ovr_cyc = 1 << 30;
   endtask

   // Drive one cycle of inputs; the model reacts as of this cycle k.
   task automatic drive(input bit sn, input logic [NV-1:0] dm,
                        input logic [8*NV-1:0] smp, input logic [NV-1:0] act);
      int k, sum, n, lat;
      exp_t ne;
      @(posedge clk);
      #2;
      sample_now   = sn;
      voice_done   = dm;
      voice_sample = smp;
      voice_active = act;
      k = cyc;
      if (sn) begin
         if (k >= fs && k <= fo) begin
            if (ovr_cyc > k + 1) ovr_cyc = k + 1;
         end else begin
            sum = 0;
            n   = 0;
            for (int i = 0; i < NV; i++) begin
               if (act[i] && (!USE_FRESH || m_fresh[i])) begin
                  sum += m_hold[i];
                  n++;
               end
            end
            lat    = (n > 0) ? (1 + NV + AW) : (2 + NV);
            ne.val = (n > 0) ? (sum / n) : 0;
            ne.cyc = k + lat;
            q.push_back(ne);
            fs = k + 1;
            fo = k + lat;
            for (int i = 0; i < NV; i++) m_fresh[i] = 1'b0;
         end
      end
      for (int i = 0; i < NV; i++) begin
         if (dm[i]) begin
            m_hold[i]  = int'(smp[8*i +: 8]);
            m_fresh[i] = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, $urandom, cur_act);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      n_rst      = 1'b0;
      sample_now = 1'b0;
      voice_done = '0;
      @(posedge clk);
      #2;
      model_clear();
      @(posedge clk);
      #2;
      n_rst = 1'b1;
   endtask

   function automatic logic [8*NV-1:0] pack4(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (mix_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = q.pop_front();
               chk("valid_cycle", cyc, e.cyc);
               chk("mix_value", int'(mix_out), e.val);
               exp_mix = e.val;
            end
         end else if (q.size() > 0 && cyc >= q[0].cyc) begin
            e = q.pop_front();
            chk("missing_valid", 0, 1);
            exp_mix = e.val;
         end
         chk("mix_out_hold", int'(mix_out), exp_mix);
         chk("busy", int'(busy), int'(cyc >= fs && cyc <= fo));
         chk("overrun", int'(overrun), int'(cyc >= ovr_cyc));
      end
   end

   initial begin
      n_rst        = 1'b0;
      sample_now   = 1'b0;
      voice_done   = '0;
      voice_sample = '0;
      voice_active = '0;
      cur_act      = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #2;
      n_rst  = 1'b1;
      mon_en = 1'b1;
      idle(2);

      // All four voices: mean of 10,20,30,40
      cur_act = 4'hF;
      drive(1'b0, 4'hF, pack4(10, 20, 30, 40), cur_act);
      drive(1'b1, 4'h0, '0, cur_act);
      idle(16);

      // Voice 3 inactive
      cur_act = 4'b0111;
      drive(1'b0, 4'hF, pack4(200, 100, 0, 255), cur_act);
      drive(1'b1, 4'h0, '0, cur_act);
      idle(16);

      // No active voices -> silence, short frame
      cur_act = 4'b0000;
      drive(1'b0, 4'hF, pack4(1, 2, 3, 4), cur_act);
      drive(1'b1, 4'h0, '0, cur_act);
      idle(8);

      // Full scale plus an ignored strobe at T+5
      cur_act = 4'hF;
      drive(1'b0, 4'hF, pack4(255, 255, 255, 255), cur_act);
      drive(1'b1, 4'h0, '0, cur_act);
      idle(4);
      drive(1'b1, 4'h0, '0, cur_act);
      idle(12);

      // Done coinciding with the snapshot
      drive(1'b0, 4'hF, pack4(40, 50, 30, 10), cur_act);
      drive(1'b1, 4'b0010, pack4(0, 99, 0, 0), cur_act);
      idle(16);
      drive(1'b1, 4'h0, '0, cur_act);
      idle(16);

      // Voice 2 silent between frames
      drive(1'b0, 4'b1011, pack4(60, 90, 7, 30), cur_act);
      drive(1'b1, 4'h0, '0, cur_act);
      idle(16);

      // Reset in the middle of NORM
      drive(1'b0, 4'hF, pack4(11, 22, 33, 44), cur_act);
      drive(1'b1, 4'h0, '0, cur_act);
      idle(7);
      do_reset();
      idle(20);

      // Random traffic
      for (int it = 0; it < 800; it++) begin
         if ($urandom_range(0, 15) == 0) cur_act = NV'($urandom);
         drive(($urandom_range(0, 11) == 0), NV'($urandom & $urandom), $urandom, cur_act);
      end
      idle(20);
      chk("drain_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_sample_mixer
`default_nettype wire
